rc_req_initiator: RTL
=====================

# rc_req_initiator

Initiator side of the rc request/acknowledge handshake. It turns a local valid/ready command into an active-low request on `rc_reqn` and holds it until the responder returns an active-low acknowledge on `rc_ackn`. It bounds each attempt with a timeout and retries a fixed number of times. Per transaction it reports completion, failure and measured response latency to the local controller.

## Interface
Parameters:
- `TIMEOUT`, 16: max cycles `rc_reqn` is held low per attempt (≥2)
- `MAX_RETRY`, 2: extra attempts after the first timeout (0 = single attempt)
- `GAP`, 1: cycles `rc_reqn` is held high between attempts and after completion (≥1)
- `CNT_W`, 8: width of latency counter (2^CNT_W > TIMEOUT)

Ports:
- `clk`  in  1  clock; all logic on rising edge
- `rstn`  in  1  reset, asynchronous, active-low
- `cmd_valid`  in  1  local request to start a transaction
- `cmd_ready`  out  1  high only in IDLE; transaction accepted on `cmd_valid & cmd_ready`
- `rc_reqn`  out  1  request to responder, active-low, registered
- `rc_ackn`  in  1  acknowledge from responder, active-low, sampled synchronously
- `busy`  out  1  high in any state other than IDLE
- `done`  out  1  one-cycle pulse: transaction acknowledged
- `err`  out  1  one-cycle pulse: all attempts timed out
- `resp_cycles`  out  CNT_W  latency of the last acknowledged attempt; held until next `done`
- `attempts`  out  2+  attempt index of the last finished transaction (1-based); held

## Operation
- States: IDLE, REQ, GAP, FAIL.
- **IDLE**
  - `rc_reqn`=1, `cmd_ready`=1.
  - On accept: go to REQ, clear wait counter, retry counter = 0.
- **REQ**
  - `rc_reqn`=0.
  - Wait counter increments each cycle, starting at 1 in the first REQ cycle.
  - `rc_ackn`=0 sampled: `resp_cycles` ← wait count, `attempts` ← retry+1, pulse `done`, go to GAP, next = IDLE.
  - Else, wait count == TIMEOUT: if retry < MAX_RETRY, retry++ and go to GAP, next = REQ; otherwise go to GAP, next = FAIL.
  - Ack and timeout in the same cycle: ack wins.
- **GAP**
  - `rc_reqn`=1 for exactly GAP cycles.
  - `rc_ackn` is ignored, since stale acks from a timed-out attempt are discarded.
  - Then go to the recorded next state.
- **FAIL**: one cycle; pulse `err`, `attempts` ← MAX_RETRY+1, go to IDLE.
- `cmd_valid` outside IDLE is ignored; it is not queued.
- The request is held low until the ack is sampled. The responder leaves its busy state on the same edge, so it always sees `rc_reqn`=1 when it returns to idle and never double-captures.
- Counters saturate at 2^CNT_W−1; they never wrap.

## Timing
- Reset (async assert, sync-safe deassert):
  - state IDLE, `rc_reqn`=1.
  - `busy`, `done`, `err`=0.
  - `resp_cycles`=0, `attempts`=0.
- Accept at edge t: `rc_reqn` low from t to the edge after which the ack is sampled.
- `done`/`err` are high for the cycle immediately after the deciding edge.
- With a responder acking on its first busy cycle, `resp_cycles`=2 (minimum legal value).
- Minimum accept-to-accept interval: resp_cycles + GAP + 1 cycles.
- `rstn` low mid-transaction:
  - `rc_reqn` returns to 1 immediately (asynchronously).
  - No `done`/`err` pulse.
  - `resp_cycles` and `attempts` are cleared.

## Structure
- Shared package `rc_pkg`:
  - state enum `rc_init_state_t` (IDLE, REQ, GAP, FAIL).
  - active-low level constants `RC_ASSERT`=0 / `RC_DEASSERT`=1, which the responder uses too.
- One natural sub-module, `rc_wait_counter`: a saturating up-counter with clear, enable and terminal-count compare. It is instantiated twice, for the REQ wait count and the GAP count.
- Outputs are registered; there is no combinational path from `rc_ackn` to `rc_reqn`.

## Test plan
- Paired with the responder model, `rc_is_idle`=1, one `cmd_valid` pulse -> `rc_reqn` low 2 cycles, `done` 1 cycle, `resp_cycles`=2, `attempts`=1, `rc_reqn` high ≥1 cycle before the next accept.
- Responder `rc_is_idle`=0 for 5 busy cycles then 1 -> `resp_cycles`=7, single `done`, no `err`.
- `rc_ackn` tied 1, TIMEOUT=16, MAX_RETRY=2 -> three 16-cycle low windows separated by 1-cycle highs, then `err` 1 cycle, `attempts`=3, `busy` drops, `cmd_ready`=1.
- Ack arriving on the timeout cycle (wait count 16) -> `done`, `resp_cycles`=16, no retry. Ack arriving 1 cycle into GAP -> ignored, retry proceeds.
- `rstn` pulsed low during REQ cycle 3 -> `rc_reqn`=1 within the reset assertion, outputs at reset values, next `cmd_valid` completes normally.
- `cmd_valid` held high continuously -> back-to-back transactions, each preceded by a GAP of `rc_reqn`=1, exactly one `done` per transaction.

Source files
------------

// File: rtl/rc_pkg.sv
// Shared definitions for the rc request/acknowledge handshake.
// Used by both the initiator and the responder side.
package rc_pkg;

    typedef enum logic [1:0] {
        RC_IDLE,
        RC_REQ,
        RC_GAP,
        RC_FAIL
    } rc_init_state_t;

    localparam logic RC_ASSERT   = 1'b0;
    localparam logic RC_DEASSERT = 1'b1;

    // Width able to hold attempt indices 1..max_retry+1, never below 2 bits.
    function automatic int rc_att_w(input int max_retry);
        int w;
        w = $clog2(max_retry + 2);
        return (w < 2) ? 2 : w;
    endfunction

endpackage

// File: rtl/rc_wait_counter.sv
// Saturating up-counter with clear, enable and terminal-count compare.
// clr together with en loads 1 so the first counted cycle reads as 1.
module rc_wait_counter #(
    parameter int W    = 8,
    parameter int TERM = 16
) (
    input  logic         clk_i,
    input  logic         rstn_i,
    input  logic         clr_i,
    input  logic         en_i,
    output logic [W-1:0] cnt_o,
    output logic         tc_o
);

    localparam logic [W-1:0] CNT_MAX = '1;
    localparam logic [W-1:0] TC_VAL  = W'(TERM);

    logic [W-1:0] cnt_q;
    logic [W-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = en_i ? W'(1) : '0;
        end else if (en_i && (cnt_q != CNT_MAX)) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt_o = cnt_q;
    assign tc_o  = (cnt_q == TC_VAL);

endmodule

// File: rtl/rc_req_initiator.sv
// Initiator of the rc request/acknowledge handshake with per-attempt
// timeout, bounded retries and latency reporting.
module rc_req_initiator
    import rc_pkg::*;
#(
    parameter  int TIMEOUT   = 16,
    parameter  int MAX_RETRY = 2,
    parameter  int GAP       = 1,
    parameter  int CNT_W     = 8,
    localparam int ATT_W     = rc_att_w(MAX_RETRY)
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    output logic             rc_reqn,
    input  logic             rc_ackn,
    output logic             busy,
    output logic             done,
    output logic             err,
    output logic [CNT_W-1:0] resp_cycles,
    output logic [ATT_W-1:0] attempts
);

    rc_init_state_t state_q, state_d;
    rc_init_state_t next_q, next_d;

    logic [ATT_W-1:0] retry_q, retry_d;
    logic [ATT_W-1:0] att_q, att_d;
    logic [CNT_W-1:0] resp_q, resp_d;
    logic             done_q, done_d;
    logic             err_q, err_d;
    logic             reqn_q, busy_q, ready_q;

    logic             wait_clr, wait_en, wait_tc;
    logic             gap_clr, gap_en, gap_tc;
    logic [CNT_W-1:0] wait_cnt;
    logic [CNT_W-1:0] gap_cnt;

    rc_wait_counter #(
        .W    (CNT_W),
        .TERM (TIMEOUT)
    ) u_wait_cnt (
        .clk_i  (clk),
        .rstn_i (rstn),
        .clr_i  (wait_clr),
        .en_i   (wait_en),
        .cnt_o  (wait_cnt),
        .tc_o   (wait_tc)
    );

    rc_wait_counter #(
        .W    (CNT_W),
        .TERM (GAP)
    ) u_gap_cnt (
        .clk_i  (clk),
        .rstn_i (rstn),
        .clr_i  (gap_clr),
        .en_i   (gap_en),
        .cnt_o  (gap_cnt),
        .tc_o   (gap_tc)
    );

    always_comb begin
        state_d  = state_q;
        next_d   = next_q;
        retry_d  = retry_q;
        att_d    = att_q;
        resp_d   = resp_q;
        done_d   = 1'b0;
        err_d    = 1'b0;
        wait_clr = 1'b0;
        wait_en  = 1'b0;
        gap_clr  = 1'b0;
        gap_en   = 1'b0;
        unique case (state_q)
            RC_IDLE: begin
                if (cmd_valid) begin
                    state_d  = RC_REQ;
                    retry_d  = '0;
                    wait_clr = 1'b1;
                    wait_en  = 1'b1;
                end
            end
            RC_REQ: begin
                // Ack beats a simultaneous timeout.
                if (rc_ackn == RC_ASSERT) begin
                    resp_d  = wait_cnt;
                    att_d   = retry_q + 1'b1;
                    done_d  = 1'b1;
                    state_d = RC_GAP;
                    next_d  = RC_IDLE;
                    gap_clr = 1'b1;
                    gap_en  = 1'b1;
                end else if (wait_tc) begin
                    state_d = RC_GAP;
                    gap_clr = 1'b1;
                    gap_en  = 1'b1;
                    if (retry_q < ATT_W'(MAX_RETRY)) begin
                        retry_d = retry_q + 1'b1;
                        next_d  = RC_REQ;
                    end else begin
                        next_d  = RC_FAIL;
                    end
                end else begin
                    wait_en = 1'b1;
                end
            end
            RC_GAP: begin
                if (gap_tc) begin
                    state_d = next_q;
                    if (next_q == RC_REQ) begin
                        wait_clr = 1'b1;
                        wait_en  = 1'b1;
                    end
                    if (next_q == RC_FAIL) begin
                        err_d = 1'b1;
                        att_d = ATT_W'(MAX_RETRY + 1);
                    end
                end else begin
                    gap_en = 1'b1;
                end
            end
            RC_FAIL: begin
                state_d = RC_IDLE;
            end
            default: begin
                state_d = RC_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q <= RC_IDLE;
            next_q  <= RC_IDLE;
            retry_q <= '0;
            att_q   <= '0;
            resp_q  <= '0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
            reqn_q  <= RC_DEASSERT;
            busy_q  <= 1'b0;
            ready_q <= 1'b1;
        end else begin
            state_q <= state_d;
            next_q  <= next_d;
            retry_q <= retry_d;
            att_q   <= att_d;
            resp_q  <= resp_d;
            done_q  <= done_d;
            err_q   <= err_d;
            reqn_q  <= (state_d == RC_REQ) ? RC_ASSERT : RC_DEASSERT;
            busy_q  <= (state_d != RC_IDLE);
            ready_q <= (state_d == RC_IDLE);
        end
    end

    assign cmd_ready   = ready_q;
    assign rc_reqn     = reqn_q;
    assign busy        = busy_q;
    assign done        = done_q;
    assign err         = err_q;
    assign resp_cycles = resp_q;
    assign attempts    = att_q;

endmodule
